// File: rtl/seq_frame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_frame_pkg
// Purpose  : Shared constants for the word-to-serial pattern sequencer:
//            FSM state encoding and the power-up detection pattern.
// Revision : 1.0  initial release
// ============================================================================
package seq_frame_pkg;

  // FSM state encoding (2-bit, legacy-compatible constants)
  localparam logic [1:0] C_ST_IDLE   = 2'b00;
  localparam logic [1:0] C_ST_SHIFT  = 2'b01;
  localparam logic [1:0] C_ST_REPORT = 2'b10;

  // Pattern loaded into the detector on reset (MSB arrives first)
  localparam logic [4:0] C_RST_PAT   = 5'b10110;

endpackage : seq_frame_pkg
`default_nettype wire

// File: rtl/seq_frame_ctrl_pat_det.sv
`default_nettype none
// ============================================================================
// Module   : pat_det
// Purpose  : Programmable overlapping Mealy pattern detector. Holds the
//            pattern register, the last PAT_W-1 bits of history and a
//            saturating count of how many history bits are valid.
// Ports    : clk    - clock, rising edge
//            rst    - asynchronous reset, active low
//            load   - load pat into the pattern register, clear history
//            pat    - new pattern (MSB is first-arriving bit)
//            clr    - clear history only
//            bit_en - consume bit_in on this clock edge
//            bit_in - current serial bit
//            match  - combinational: history plus bit_in equals pattern
// Revision : 1.0  initial release
// ============================================================================
module pat_det
  import seq_frame_pkg::*;
#(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(C_RST_PAT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [PAT_W-1:0] pat,
  input  logic             clr,
  input  logic             bit_en,
  input  logic             bit_in,
  output logic             match
);

  localparam int              SEEN_W     = $clog2(PAT_W);
  localparam logic [SEEN_W-1:0] C_SEEN_MAX = SEEN_W'(PAT_W - 1);

  logic [PAT_W-1:0]  r_pat;
  logic [PAT_W-2:0]  r_hist;
  logic [SEEN_W-1:0] r_seen;
  logic [PAT_W-2:0]  w_hist_nxt;

  // A two-bit pattern keeps only one history bit, so the shift degenerates.
  generate
    if (PAT_W == 2) begin : g_hist_one
      assign w_hist_nxt = bit_in;
    end else begin : g_hist_wide
      assign w_hist_nxt = {r_hist[PAT_W-3:0], bit_in};
    end
  endgenerate

  // Match only once a full PAT_W-1 bits of history exist since the last clear.
  assign match = ({r_hist, bit_in} == r_pat) && (r_seen == C_SEEN_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat  <= RST_PAT;
      r_hist <= '0;
      r_seen <= '0;
    end else if (load) begin
      r_pat  <= pat;
      r_hist <= '0;
      r_seen <= '0;
    end else if (clr) begin
      r_hist <= '0;
      r_seen <= '0;
    end else if (bit_en) begin
      r_hist <= w_hist_nxt;
      if (r_seen != C_SEEN_MAX) begin
        r_seen <= r_seen + SEEN_W'(1);
      end
    end
  end

endmodule : pat_det
`default_nettype wire

// File: rtl/seq_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_frame_ctrl
// Purpose  : Accepts a parallel word over valid/ready, feeds it MSB-first
//            one bit per clock into pat_det, and reports the number of
//            matches plus a per-bit match bitmap over a valid/ready port.
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous reset, active low
//            cfg_we    - pattern write strobe (effective in IDLE only)
//            cfg_pat   - new pattern
//            cont      - sampled at accept; 1 keeps detector history
//            in_valid  - input word valid
//            in_ready  - input ready (IDLE and no cfg write)
//            in_data   - input word
//            out_valid - result valid (REPORT)
//            out_ready - result accepted
//            out_count - number of matches in the word
//            match_map - bit k set when a match completed on in_data[k]
// Revision : 1.0  initial release
// ============================================================================
module seq_frame_ctrl
  import seq_frame_pkg::*;
#(
  parameter int               DATA_W  = 16,
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(C_RST_PAT),
  parameter int               CNT_W   = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pat,
  input  logic              cont,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic [DATA_W-1:0] match_map
);

  localparam int               IDX_W      = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(DATA_W - 1);

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_word;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_map;

  logic w_idle;
  logic w_shift;
  logic w_accept;
  logic w_load;
  logic w_clr;
  logic w_match;
  logic w_hit;

  assign w_idle   = (r_state == C_ST_IDLE);
  assign w_shift  = (r_state == C_ST_SHIFT);
  assign in_ready = w_idle && !cfg_we;
  assign w_accept = in_valid && in_ready;
  assign w_load   = w_idle && cfg_we;
  assign w_clr    = w_accept && !cont;
  assign w_hit    = w_shift && w_match;

  assign out_valid = (r_state == C_ST_REPORT);
  assign out_count = r_count;
  assign match_map = r_map;

  // The word register shifts left so the current bit is always its MSB.
  pat_det #(
    .PAT_W   (PAT_W),
    .RST_PAT (RST_PAT)
  ) u_pat_det (
    .clk    (clk),
    .rst    (rst),
    .load   (w_load),
    .pat    (cfg_pat),
    .clr    (w_clr),
    .bit_en (w_shift),
    .bit_in (r_word[DATA_W-1]),
    .match  (w_match)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= C_ST_IDLE;
      r_word  <= '0;
      r_idx   <= '0;
      r_count <= '0;
      r_map   <= '0;
    end else begin
      case (r_state)
        C_ST_IDLE: begin
          if (w_accept) begin
            r_word  <= in_data;
            r_idx   <= '0;
            r_count <= '0;
            r_map   <= '0;
            r_state <= C_ST_SHIFT;
          end
        end
        C_ST_SHIFT: begin
          r_word  <= {r_word[DATA_W-2:0], 1'b0};
          // Shifting the map left lands the first bit's flag at DATA_W-1
          // after DATA_W steps, matching its position in the input word.
          r_map   <= {r_map[DATA_W-2:0], w_hit};
          r_count <= r_count + CNT_W'(w_hit);
          r_idx   <= r_idx + IDX_W'(1);
          if (r_idx == C_IDX_LAST) begin
            r_state <= C_ST_REPORT;
          end
        end
        C_ST_REPORT: begin
          if (out_ready) begin
            r_state <= C_ST_IDLE;
          end
        end
        default: r_state <= C_ST_IDLE;
      endcase
    end
  end

endmodule : seq_frame_ctrl
`default_nettype wire

// File: tb/tb_seq_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_frame_ctrl
// Purpose  : Scoreboard bench for seq_frame_ctrl with a queue-based
//            behavioural reference model of the pattern detector.
// Revision : 1.0  initial release
// ============================================================================
module tb_seq_frame_ctrl;

  localparam int DATA_W = 16;
  localparam int PAT_W  = 5;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [PAT_W-1:0]  cfg_pat;
  logic              cont;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  out_count;
  logic [DATA_W-1:0] match_map;

  seq_frame_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_pat   (cfg_pat),
    .cont      (cont),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .match_map (match_map)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int map;
  } res_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  res_t sbq[$];
  int   m_pat;
  int   m_hist[$];
  bit   rnd_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout_stop(input string name);
    total++;
    bad++;
    $display("FAIL %s timeout", name);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // Reference: keep the bit stream since the last clear; a match is the
  // last PAT_W-1 stored bits followed by the new bit equalling the pattern.
  function automatic res_t model_word(input logic [DATA_W-1:0] d, input bit c);
    res_t r;
    r.cnt = 0;
    r.map = 0;
    if (!c) m_hist.delete();
    for (int i = 0; i < DATA_W; i++) begin
      int b;
      int w;
      b = int'(d[DATA_W-1-i]);
      if (m_hist.size() == PAT_W - 1) begin
        w = 0;
        foreach (m_hist[j]) w = w * 2 + m_hist[j];
        w = w * 2 + b;
        if (w == m_pat) begin
          r.cnt++;
          r.map = r.map | (1 << (DATA_W - 1 - i));
        end
      end
      m_hist.push_back(b);
      if (m_hist.size() > PAT_W - 1) void'(m_hist.pop_front());
    end
    return r;
  endfunction

  // Monitor: every completed result handshake is checked against the queue.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result count=%0d map=%0h required=none", out_count, match_map);
      end else begin
        res_t e;
        e = sbq.pop_front();
        check("result_count", 32'(out_count), 32'(e.cnt));
        check("result_map", 32'(match_map), 32'(e.map));
      end
    end
  end

  // All tasks start and end at posedge+#1.
  task automatic wait_accept(output int waited);
    waited = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waited++;
      if (waited > 100) timeout_stop("accept_wait");
    end
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input bit c, input bit hold_valid);
    int w;
    in_data  = d;
    cont     = c;
    in_valid = 1'b1;
    wait_accept(w);
    sbq.push_back(model_word(d, c));
    @(posedge clk);
    #1;
    if (!hold_valid) in_valid = 1'b0;
  endtask

  // Returns with the DUT in REPORT, sampled at the negedge.
  task automatic wait_valid(output int n);
    n = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      if (n > 100) timeout_stop("result_wait");
    end
  endtask

  task automatic expect_result(input string name, input int cnt, input int map);
    int n;
    wait_valid(n);
    check({name, "_count"}, 32'(out_count), 32'(cnt));
    check({name, "_map"}, 32'(match_map), 32'(map));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready && !out_valid) break;
      n++;
      if (n > 200) timeout_stop("idle_wait");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_pattern(input logic [PAT_W-1:0] p);
    cfg_we  = 1'b1;
    cfg_pat = p;
    @(negedge clk);
    check("cfg_blocks_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    m_pat  = int'(p);
    m_hist.delete();
  endtask

  initial begin
    int n;
    int w;
    int last_acc;
    rst       = 1'b0;
    cfg_we    = 1'b0;
    cfg_pat   = '0;
    cont      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    rnd_done  = 1'b0;
    m_pat     = 5'b10110;
    m_hist.delete();

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_count", 32'(out_count), 32'd0);
    check("reset_match_map", 32'(match_map), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Default pattern, latency to out_valid
    send_word(16'hB6C0, 1'b0, 1'b0);
    wait_valid(n);
    check("latency_edges", 32'(n), 32'd16);
    check("b6c0_count", 32'(out_count), 32'd3);
    check("b6c0_map", 32'(match_map), 32'h0920);
    @(posedge clk);
    #1;

    // History carry across words
    send_word(16'h000B, 1'b1, 1'b0);
    expect_result("cont1_w0", 0, 0);
    send_word(16'h0000, 1'b1, 1'b0);
    expect_result("cont1_w1", 1, 16'h8000);
    send_word(16'h000B, 1'b0, 1'b0);
    expect_result("cont0_w0", 0, 0);
    send_word(16'h0000, 1'b0, 1'b0);
    expect_result("cont0_w1", 0, 0);

    // Reprogram in IDLE; a write during SHIFT must be ignored
    cfg_pattern(5'b11111);
    send_word(16'hFFFF, 1'b0, 1'b0);
    expect_result("ones_a", 12, 16'h0FFF);
    send_word(16'hFFFF, 1'b0, 1'b0);
    cfg_we  = 1'b1;
    cfg_pat = 5'b00000;
    repeat (2) @(posedge clk);
    #1;
    cfg_we = 1'b0;
    expect_result("ones_shift_cfg", 12, 16'h0FFF);
    send_word(16'hFFFF, 1'b0, 1'b0);
    expect_result("ones_b", 12, 16'h0FFF);
    cfg_pattern(5'b10110);

    // Backpressure in REPORT
    out_ready = 1'b0;
    send_word(16'hB6C0, 1'b0, 1'b0);
    wait_valid(n);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 16'h5AB6;
    cont     = 1'b1;
    cfg_we   = 1'b1;
    cfg_pat  = 5'b00000;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_count", 32'(out_count), 32'd3);
      check("bp_map", 32'(match_map), 32'h0920);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    cfg_we    = 1'b0;
    out_ready = 1'b1;
    wait_accept(w);
    check("bp_release_accept_delay", 32'(w), 32'd1);
    sbq.push_back(model_word(16'h5AB6, 1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_idle();

    // Reset mid-SHIFT with a non-default pattern loaded
    cfg_pattern(5'b11111);
    send_word(16'hB6C0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_count", 32'(out_count), 32'd0);
    check("midrst_match_map", 32'(match_map), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    sbq.delete();
    m_pat = 5'b10110;
    m_hist.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    send_word(16'hB6C0, 1'b1, 1'b0);
    expect_result("post_rst", 3, 16'h0920);

    // Back-to-back with in_valid and out_ready held high
    last_acc = -1;
    for (int k = 0; k < 6; k++) begin
      logic [DATA_W-1:0] d;
      bit c;
      d = 16'($urandom);
      c = 1'($urandom);
      in_data  = d;
      cont     = c;
      in_valid = 1'b1;
      wait_accept(w);
      if (last_acc >= 0) check("b2b_spacing", 32'(cyc - last_acc), 32'd18);
      last_acc = cyc;
      sbq.push_back(model_word(d, c));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_idle();

    // Randomized traffic with random backpressure and reprogramming
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          logic [DATA_W-1:0] d;
          if ($urandom_range(0, 4) == 0) begin
            wait_idle();
            cfg_pattern(5'($urandom));
          end
          case ($urandom_range(0, 2))
            0:       d = 16'($urandom);
            1:       d = {3'($urandom), 5'(m_pat), 3'($urandom), 5'(m_pat)};
            default: d = {16{1'($urandom)}} ^ 16'($urandom_range(0, 3));
          endcase
          send_word(d, 1'($urandom), 1'b0);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_frame_ctrl
`default_nettype wire
